disp_bin2bcd: RTL and testbench

//  Sequential double-dabble converter: turns a binary value into packed BCD digits for the
//  8-digit multiplexed seven-segment driver, sitting directly upstream of its 32-bit data input.

---
 rtl/disp_pkg.sv | 14 +
 rtl/bcd_digit_adj.sv | 12 +
 rtl/disp_bin2bcd.sv | 143 ++++++++++++++
 tb/tb_disp_bin2bcd.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared constants and state encodings for the seven-segment display path.
package disp_pkg;

    localparam int         DIGIT_W         = 4;
    localparam logic [3:0] BCD_SAT_DIGIT   = 4'h9;
    localparam logic [3:0] BCD_MINUS_DIGIT = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_LOAD = 2'd2
    } disp_state_e;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more before the next shift.
module bcd_digit_adj
    import disp_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [DIGIT_W-1:0] digit_o
);

    // Only 5..9 reach the adder in a valid conversion, so the 4-bit sum never wraps.
    assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/disp_bin2bcd.sv
// Iterative binary-to-BCD converter feeding the 8-digit seven-segment driver.
// Optional BIN2BCD_SIGNED_EN: two's-complement input, top digit carries the minus marker.
module disp_bin2bcd
    import disp_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 8
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    i_start,
    input  logic [WIDTH-1:0]        i_bin,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [4*DIGITS-1:0]     o_bcd,
    output logic                    o_ovf
);

    // state  | meaning
    // S_IDLE | waiting for i_start, result registers held
    // S_CONV | one add-3/shift step per clock, WIDTH steps
    // S_LOAD | publish result (or saturated value), pulse o_done

`ifdef BIN2BCD_SIGNED_EN
    localparam int NUMD = DIGITS - 1;
`else
    localparam int NUMD = DIGITS;
`endif
    localparam int SW    = NUMD * DIGIT_W;
    localparam int CNT_W = $clog2(WIDTH + 1);

    disp_state_e          state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [WIDTH-1:0]     shift_q, shift_d;
    logic [SW-1:0]        scratch_q, scratch_d;
    logic [SW-1:0]        adj;
    logic                 ovf_int_q, ovf_int_d;
    logic [4*DIGITS-1:0]  bcd_q, bcd_d;
    logic                 ovf_q, ovf_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     operand;
    logic [4*DIGITS-1:0]  result;

    for (genvar g = 0; g < NUMD; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (scratch_q[g*DIGIT_W +: DIGIT_W]),
            .digit_o (adj[g*DIGIT_W +: DIGIT_W])
        );
    end

`ifdef BIN2BCD_SIGNED_EN
    logic neg_q, neg_d;

    // Unsigned negate so the most negative input yields its exact magnitude.
    assign operand = i_bin[WIDTH-1] ? (~i_bin + 1'b1) : i_bin;
    assign result  = {(neg_q ? BCD_MINUS_DIGIT : 4'h0),
                      (ovf_int_q ? {NUMD{BCD_SAT_DIGIT}} : scratch_q)};

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) neg_q <= 1'b0;
        else        neg_q <= neg_d;
    end

    always_comb begin
        neg_d = neg_q;
        if (state_q == S_IDLE && i_start) neg_d = i_bin[WIDTH-1];
    end
`else
    assign operand = i_bin;
    assign result  = ovf_int_q ? {NUMD{BCD_SAT_DIGIT}} : scratch_q;
`endif

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            shift_q   <= '0;
            scratch_q <= '0;
            ovf_int_q <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            ovf_int_q <= ovf_int_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        ovf_int_d = ovf_int_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    shift_d   = operand;
                    scratch_d = '0;
                    ovf_int_d = 1'b0;
                    count_d   = CNT_W'(WIDTH);
                    busy_d    = 1'b1;
                    state_d   = S_CONV;
                end
            end
            S_CONV: begin
                // A bit carried out of the top numeric digit means the value cannot fit.
                scratch_d = {adj[SW-2:0], shift_q[WIDTH-1]};
                shift_d   = {shift_q[WIDTH-2:0], 1'b0};
                ovf_int_d = ovf_int_q | adj[SW-1];
                count_d   = count_q - 1'b1;
                if (count_q == CNT_W'(1)) state_d = S_LOAD;
            end
            S_LOAD: begin
                bcd_d   = result;
                ovf_d   = ovf_int_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_bcd  = bcd_q;
    assign o_ovf  = ovf_q;

endmodule

// File: tb/tb_disp_bin2bcd.sv
// Scoreboard bench for disp_bin2bcd; expected results and done timing queued at each start.
module tb_disp_bin2bcd;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        i_start = 1'b0;
    logic [31:0] i_bin = '0;
    logic        o_busy, o_done, o_ovf;
    logic [31:0] o_bcd;

    typedef struct {
        logic [31:0] bcd;
        logic        ovf;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] bin;
        logic [31:0] bcd;
        logic        ovf;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    disp_bin2bcd #(.WIDTH(32), .DIGITS(8)) dut (
        .CLK     (CLK),
        .reset   (reset),
        .i_start (i_start),
        .i_bin   (i_bin),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_bcd   (o_bcd),
        .o_ovf   (o_ovf)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Start sampled on the next rising edge k; done is visible at the negedge after edge k+33.
    task automatic push_exp(input logic [31:0] bcd, input logic ovf);
        sb.push_back('{bcd: bcd, ovf: ovf, cyc: cyc + 34});
    endtask

    task automatic start_conv(input logic [31:0] bin, input logic [31:0] bcd, input logic ovf);
        @(negedge CLK);
        i_start = 1'b1;
        i_bin   = bin;
        push_exp(bcd, ovf);
        @(negedge CLK);
        i_start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || o_busy) && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 100) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_idle: timeout with %0d results pending", sb.size());
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_bcd"},  o_bcd,  0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_ovf"},  o_ovf,  0);
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            if (o_done === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_done: got done with bcd %h, expected none", o_bcd);
                end else begin
                    mon_e = sb.pop_front();
                    chk("result_bcd", o_bcd, mon_e.bcd);
                    chk("result_ovf", o_ovf, mon_e.ovf);
                    chk("done_latency_cycle", cyc, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        vec_t vecs[$];
        int   busy_cnt;
        int   n;

`ifdef BIN2BCD_SIGNED_EN
        vecs.push_back('{bin: 32'hFFFFFFFF, bcd: 32'hF0000001, ovf: 1'b0});
        vecs.push_back('{bin: 32'hFF676981, bcd: 32'hF9999999, ovf: 1'b0});
        vecs.push_back('{bin: 32'hFF676980, bcd: 32'hF9999999, ovf: 1'b1});
        vecs.push_back('{bin: 32'h80000000, bcd: 32'hF9999999, ovf: 1'b1});
        vecs.push_back('{bin: 32'd123,      bcd: 32'h00000123, ovf: 1'b0});
        vecs.push_back('{bin: 32'd9999999,  bcd: 32'h09999999, ovf: 1'b0});
        vecs.push_back('{bin: 32'd10000000, bcd: 32'h09999999, ovf: 1'b1});
`else
        vecs.push_back('{bin: 32'd99999999,  bcd: 32'h99999999, ovf: 1'b0});
        vecs.push_back('{bin: 32'd100000000, bcd: 32'h99999999, ovf: 1'b1});
        vecs.push_back('{bin: 32'hFFFFFFFF,  bcd: 32'h99999999, ovf: 1'b1});
        vecs.push_back('{bin: 32'd10,        bcd: 32'h00000010, ovf: 1'b0});
        vecs.push_back('{bin: 32'd9,         bcd: 32'h00000009, ovf: 1'b0});
`endif

        // 1: reset values, reset in idle, zero conversion
        repeat (3) @(negedge CLK);
        chk_outputs_zero("por");
        reset = 1'b1;
        repeat (2) @(negedge CLK);
        #2 reset = 1'b0;
        #1 chk_outputs_zero("idle_reset");
        @(negedge CLK);
        reset = 1'b1;
        start_conv(32'd0, 32'h00000000, 1'b0);
        wait_idle();

        // 2: busy width and single-cycle done
        @(negedge CLK);
        i_start = 1'b1;
`ifdef BIN2BCD_SIGNED_EN
        i_bin = 32'd1234567;
        push_exp(32'h01234567, 1'b0);
`else
        i_bin = 32'd12345678;
        push_exp(32'h12345678, 1'b0);
`endif
        busy_cnt = 0;
        n = 0;
        do begin
            @(negedge CLK);
            i_start = 1'b0;
            if (o_busy) busy_cnt++;
            n++;
        end while (!o_done && n < 60);
        chk("busy_cycles", busy_cnt, 33);
        chk("busy_low_at_done", o_busy, 0);
        @(negedge CLK);
        chk("done_one_cycle", o_done, 0);
        wait_idle();

        // 3: boundary and saturation vectors
        foreach (vecs[i]) begin
            start_conv(vecs[i].bin, vecs[i].bcd, vecs[i].ovf);
            wait_idle();
        end

        // 4: start while busy is ignored; start in the done cycle is accepted
        start_conv(32'd42, 32'h00000042, 1'b0);
        repeat (4) @(negedge CLK);
        i_start = 1'b1;
        i_bin   = 32'd7;
        @(negedge CLK);
        i_start = 1'b0;
        n = 0;
        while (!o_done && n < 60) begin
            @(negedge CLK);
            n++;
        end
        chk("b2b_done_seen", o_done, 1);
        i_start = 1'b1;
        i_bin   = 32'd7;
        push_exp(32'h00000007, 1'b0);
        @(negedge CLK);
        i_start = 1'b0;
        chk("b2b_busy", o_busy, 1);
        wait_idle();

        // 5: reset mid-conversion aborts without a done pulse
        @(negedge CLK);
        i_start = 1'b1;
        i_bin   = 32'd12345;
        @(negedge CLK);
        i_start = 1'b0;
        repeat (9) @(negedge CLK);
        #2 reset = 1'b0;
        #1 chk_outputs_zero("abort_reset");
        repeat (2) @(negedge CLK);
        reset = 1'b1;
        repeat (40) @(negedge CLK);
        chk("abort_no_busy", o_busy, 0);
        start_conv(32'd305, 32'h00000305, 1'b0);
        wait_idle();

        repeat (3) @(negedge CLK);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
